// File: rtl/match_ctrl_pkg.sv
// Shared constants and types for the pong match sequencer.
package match_ctrl_pkg;

   typedef logic [2:0] state_t;
   typedef logic [3:0] score_t;
   typedef logic [1:0] winner_t;

   typedef struct packed {
      score_t p1;
      score_t p2;
   } scores_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SERVE = 3'd1;
   localparam state_t ST_RALLY = 3'd2;
   localparam state_t ST_POINT = 3'd3;
   localparam state_t ST_OVER  = 3'd4;

   localparam winner_t WIN_NONE = 2'b00;
   localparam winner_t WIN_P1   = 2'b01;
   localparam winner_t WIN_P2   = 2'b10;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   function automatic score_t score_inc(input score_t s);
      return s + 4'd1;
   endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Game-flow signal bundle between the ball engine/VGA side and the match sequencer.
interface match_ctrl_if import match_ctrl_pkg::*; ();

   logic       tick;
   logic       start;
   logic       out_left;
   logic       out_right;
   logic [4:0] entropy;

   logic       serve;
   logic       serve_dir;
   logic       ball_en;
   logic       flash;
   score_t     score_p1;
   score_t     score_p2;
   winner_t    winner;
   state_t     state;

   modport master (
      output tick, start, out_left, out_right, entropy,
      input  serve, serve_dir, ball_en, flash, score_p1, score_p2, winner, state
   );

   modport slave (
      input  tick, start, out_left, out_right, entropy,
      output serve, serve_dir, ball_en, flash, score_p1, score_p2, winner, state
   );

endinterface

// File: rtl/match_ctrl_tick_timer.sv
// Loadable down-counter advanced by game ticks; holds at zero and flags it.
module tick_timer #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_tick,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: attract, serve, rally, point flash and game-over phases,
// owning the scores and the serve launch/direction.
module match_ctrl import match_ctrl_pkg::*; #(
   parameter int unsigned WIN_SCORE   = 9,
   parameter int unsigned SERVE_TICKS = 375,
   parameter int unsigned POINT_TICKS = 750,
   parameter int unsigned TIMERWIDTH  = 10
) (
   input logic         clk,
   input logic         reset,
   match_ctrl_if.slave bus
);

   localparam logic [TIMERWIDTH-1:0] LP_SERVE = TIMERWIDTH'(SERVE_TICKS);
   localparam logic [TIMERWIDTH-1:0] LP_POINT = TIMERWIDTH'(POINT_TICKS);
   localparam score_t                LP_WIN   = score_t'(WIN_SCORE);

   state_t  r_state;
   scores_t r_score;
   winner_t r_winner;
   logic    r_serve;
   logic    r_serve_dir;

   logic                  w_load;
   logic [TIMERWIDTH-1:0] w_load_value;
   logic                  w_zero;
   logic                  w_p1_won;
   logic                  w_p2_won;
   logic                  w_unused;

   assign w_p1_won = (r_score.p1 == LP_WIN);
   assign w_p2_won = (r_score.p2 == LP_WIN);
   assign w_unused = ^bus.entropy[4:1];

   // Timer is reloaded on every entry into SERVE or POINT; its count elsewhere is don't-care.
   always_comb begin
      w_load       = 1'b0;
      w_load_value = LP_SERVE;
      case (r_state)
         ST_IDLE, ST_OVER: begin
            w_load = bus.start;
         end
         ST_RALLY: begin
            if (bus.out_left || bus.out_right) begin
               w_load       = 1'b1;
               w_load_value = LP_POINT;
            end
         end
         ST_POINT: begin
            w_load = w_zero && !w_p1_won && !w_p2_won;
         end
         default: begin
            w_load = 1'b0;
         end
      endcase
   end

   tick_timer #(
      .WIDTH(TIMERWIDTH)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_value (w_load_value),
      .i_tick  (bus.tick),
      .o_zero  (w_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_score     <= '0;
         r_winner    <= WIN_NONE;
         r_serve     <= 1'b0;
         r_serve_dir <= DIR_LEFT;
      end else begin
         r_serve <= 1'b0;
         case (r_state)
            ST_IDLE, ST_OVER: begin
               if (bus.start) begin
                  r_state     <= ST_SERVE;
                  r_score     <= '0;
                  r_winner    <= WIN_NONE;
                  r_serve_dir <= bus.entropy[0];
               end
            end
            ST_SERVE: begin
               if (w_zero) begin
                  r_serve <= 1'b1;
                  r_state <= ST_RALLY;
               end
            end
            ST_RALLY: begin
               // Both sides out on the same clock is a replay: no score, direction kept.
               if (bus.out_left && !bus.out_right) begin
                  r_score.p2  <= score_inc(r_score.p2);
                  r_serve_dir <= DIR_LEFT;
               end else if (bus.out_right && !bus.out_left) begin
                  r_score.p1  <= score_inc(r_score.p1);
                  r_serve_dir <= DIR_RIGHT;
               end
               if (bus.out_left || bus.out_right) begin
                  r_state <= ST_POINT;
               end
            end
            ST_POINT: begin
               if (w_zero) begin
                  if (w_p1_won) begin
                     r_state  <= ST_OVER;
                     r_winner <= WIN_P1;
                  end else if (w_p2_won) begin
                     r_state  <= ST_OVER;
                     r_winner <= WIN_P2;
                  end else begin
                     r_state <= ST_SERVE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.serve     = r_serve;
   assign bus.serve_dir = r_serve_dir;
   assign bus.ball_en   = (r_state == ST_RALLY);
   assign bus.flash     = (r_state == ST_POINT);
   assign bus.score_p1  = r_score.p1;
   assign bus.score_p2  = r_score.p2;
   assign bus.winner    = r_winner;
   assign bus.state     = r_state;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with a phase-level reference model checked every cycle.
module tb_match_ctrl;

   localparam int WIN   = 3;
   localparam int SERVT = 3;
   localparam int PNTT  = 2;

   localparam int P_IDLE  = 0;
   localparam int P_SERVE = 1;
   localparam int P_RALLY = 2;
   localparam int P_POINT = 3;
   localparam int P_OVER  = 4;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   match_ctrl_if bus ();

   match_ctrl #(
      .WIN_SCORE   (WIN),
      .SERVE_TICKS (SERVT),
      .POINT_TICKS (PNTT),
      .TIMERWIDTH  (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: game phase, remaining ticks, scores, last serve direction.
   int   m_phase = P_IDLE;
   int   m_left  = 0;
   int   m_p1    = 0;
   int   m_p2    = 0;
   int   m_win   = 0;
   logic m_dir   = 1'b0;
   logic m_serve = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = P_IDLE; m_left = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
         m_dir = 1'b0; m_serve = 1'b0;
      end else begin
         m_serve = 1'b0;
         if (m_phase == P_IDLE || m_phase == P_OVER) begin
            if (bus.start) begin
               m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = bus.entropy[0];
               m_phase = P_SERVE; m_left = SERVT;
            end
         end else if (m_phase == P_SERVE) begin
            if (m_left == 0) begin m_serve = 1'b1; m_phase = P_RALLY; end
            else if (bus.tick) m_left = m_left - 1;
         end else if (m_phase == P_RALLY) begin
            if (bus.out_left || bus.out_right) begin
               if (bus.out_left && !bus.out_right) begin m_p2 = m_p2 + 1; m_dir = 1'b0; end
               if (bus.out_right && !bus.out_left) begin m_p1 = m_p1 + 1; m_dir = 1'b1; end
               m_phase = P_POINT; m_left = PNTT;
            end
         end else begin
            if (m_left == 0) begin
               if (m_p1 == WIN)      begin m_phase = P_OVER; m_win = 1; end
               else if (m_p2 == WIN) begin m_phase = P_OVER; m_win = 2; end
               else begin m_phase = P_SERVE; m_left = SERVT; end
            end else if (bus.tick) m_left = m_left - 1;
         end
      end
   end

   logic [16:0] w_dut_vec;
   logic [16:0] w_mdl_vec;
   assign w_dut_vec = {bus.serve, bus.serve_dir, bus.ball_en, bus.flash,
                       bus.score_p1, bus.score_p2, bus.winner, bus.state};
   assign w_mdl_vec = {m_serve, m_dir, (m_phase == P_RALLY), (m_phase == P_POINT),
                       4'(m_p1), 4'(m_p2), 2'(m_win), 3'(m_phase)};

   always @(negedge clk) begin
      checks++;
      if (w_dut_vec !== w_mdl_vec) begin
         errors++;
         $display("FAIL model_cmp t=%0t: dut {srv,dir,ben,fl,p1,p2,win,st}=%h model=%h",
                  $time, w_dut_vec, w_mdl_vec);
      end
   end

   // Tick every 4 clocks.
   initial begin
      int tcnt;
      tcnt = 0;
      bus.tick = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         bus.tick = (tcnt == 3);
         tcnt = (tcnt + 1) % 4;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_start(input logic e);
      #1;
      bus.start   = 1'b1;
      bus.entropy = {4'b1010, e};
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drive_outs(input logic l, input logic r);
      #1;
      bus.out_left  = l;
      bus.out_right = r;
      @(negedge clk);
   endtask

   task automatic wait_serve(output int nt);
      int n;
      nt = 0;
      n  = 0;
      @(negedge clk);
      while (bus.serve !== 1'b1 && n < 200) begin
         if (bus.tick) nt++;
         n++;
         @(negedge clk);
      end
      chk("serve_timeout", int'(bus.serve === 1'b1), 1);
      chk("ball_en_at_serve", int'(bus.ball_en), 1);
   endtask

   task automatic after_serve();
      #1;
      bus.out_left  = 1'b0;
      bus.out_right = 1'b0;
      @(negedge clk);
      chk("serve_single_pulse", int'(bus.serve), 0);
      chk("ball_en_rally", int'(bus.ball_en), 1);
   endtask

   task automatic wait_state(input int st);
      int n;
      n = 0;
      while (int'(bus.state) != st && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("state_timeout", int'(bus.state), st);
   endtask

   initial begin
      int nt;
      reset = 1'b1;
      bus.start = 1'b0; bus.out_left = 1'b0; bus.out_right = 1'b0; bus.entropy = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_state", int'(bus.state), 0);
      chk("rst_scores", int'({bus.score_p1, bus.score_p2}), 0);
      chk("rst_outs", int'({bus.serve, bus.serve_dir, bus.ball_en, bus.flash, bus.winner}), 0);
      repeat (2) @(negedge clk);

      pulse_start(1'b1);
      chk("start_state", int'(bus.state), 1);
      chk("start_dir", int'(bus.serve_dir), 1);
      wait_serve(nt);
      chk("serve_latency_ticks", nt, 3);
      chk("rally_state", int'(bus.state), 2);
      after_serve();

      drive_outs(1'b1, 1'b0);
      chk("left_out_p2", int'(bus.score_p2), 1);
      chk("left_out_dir", int'(bus.serve_dir), 0);
      chk("left_out_flash", int'(bus.flash), 1);
      wait_serve(nt);
      after_serve();

      drive_outs(1'b1, 1'b1);
      chk("replay_state", int'(bus.state), 3);
      chk("replay_scores", int'({bus.score_p1, bus.score_p2}), 8'h01);
      wait_serve(nt);
      chk("replay_dir", int'(bus.serve_dir), 0);
      after_serve();

      pulse_start(1'b1);
      chk("start_in_rally", int'(bus.state), 2);
      drive_outs(1'b0, 1'b1);
      chk("p1_point1", int'({bus.score_p1, bus.score_p2}), 8'h11);
      chk("right_out_dir", int'(bus.serve_dir), 1);
      pulse_start(1'b0);
      chk("start_in_point", int'(bus.state), 3);
      chk("start_in_point_sc", int'({bus.score_p1, bus.score_p2}), 8'h11);
      wait_serve(nt);
      after_serve();
      drive_outs(1'b0, 1'b1);
      wait_serve(nt);
      after_serve();
      drive_outs(1'b0, 1'b1);
      chk("win_point_flash", int'(bus.flash), 1);
      chk("win_point_state", int'(bus.state), 3);
      wait_state(4);
      chk("over_winner", int'(bus.winner), 1);
      chk("over_p1", int'(bus.score_p1), 3);
      drive_outs(1'b1, 1'b0);
      repeat (20) @(negedge clk);
      chk("over_frozen", int'({bus.state, bus.score_p1, bus.score_p2, bus.winner}),
          int'({3'd4, 4'd3, 4'd1, 2'b01}));
      drive_outs(1'b0, 1'b0);

      pulse_start(1'b0);
      chk("restart_state", int'(bus.state), 1);
      chk("restart_clear", int'({bus.score_p1, bus.score_p2, bus.winner}), 0);
      wait_serve(nt);
      after_serve();
      drive_outs(1'b1, 1'b0);
      wait_serve(nt);
      after_serve();
      drive_outs(1'b0, 1'b1);
      wait_serve(nt);
      after_serve();
      drive_outs(1'b0, 1'b1);
      chk("pre_reset_score", int'({bus.score_p1, bus.score_p2}), 8'h21);
      chk("pre_reset_flash", int'(bus.flash), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_reset_state", int'(bus.state), 0);
      chk("mid_reset_flash", int'(bus.flash), 0);
      chk("mid_reset_all", int'(w_dut_vec), 0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      bus.out_left = 1'b0; bus.out_right = 1'b0;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
